theta_stream: RTL and testbench

Plane-serial Keccak theta step, parametrised in lane width W, giving Keccak-f[25·W] for W = 1…64. A state arrives as five plane beats (y = 0…4) on a valid/ready input. The block buffers the planes and accumulates column parity, then emits five theta-transformed plane beats on a valid/ready output. It sits between the absorb/round-control datapath and the rho/pi stages in narrow-width and area-reduced SHA-3 variants.

---
 rtl/keccak_pkg.sv | 22 ++
 rtl/theta_d.sv | 21 ++
 rtl/theta_stream.sv | 108 ++++++++++
 tb/tb_theta_stream.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/keccak_pkg.sv
// Shared Keccak dimensions, full-width plane/state types and the theta_stream FSM encoding.
package keccak_pkg;

   localparam int X_DIM      = 5;
   localparam int Y_DIM      = 5;
   localparam int LANE_W_MAX = 64;

   typedef logic [LANE_W_MAX-1:0] lane_t;
   typedef lane_t [X_DIM-1:0]     plane_t;
   typedef plane_t [Y_DIM-1:0]    state_t;

   typedef enum logic [0:0] {
      LOAD  = 1'b0,
      DRAIN = 1'b1
   } theta_state_e;

   function automatic bit lane_w_legal(input int w);
      return (w == 1) || (w == 2) || (w == 4) || (w == 8) ||
             (w == 16) || (w == 32) || (w == 64);
   endfunction

endpackage

// File: rtl/theta_d.sv
// Theta column-mix term: D[x][z] = C[x-1][z] ^ C[x+1][z-1], x mod 5, z mod W.
module theta_d
   import keccak_pkg::*;
#(
   parameter int W = 64
) (
   input  logic [X_DIM*W-1:0] c,
   output logic [X_DIM*W-1:0] d
);

   always_comb begin
      d = '0;
      for (int x = 0; x < X_DIM; x++) begin
         for (int z = 0; z < W; z++) begin
            d[x*W + z] = c[((x + X_DIM - 1) % X_DIM)*W + z] ^
                         c[((x + 1) % X_DIM)*W + ((z + W - 1) % W)];
         end
      end
   end

endmodule

// File: rtl/theta_stream.sv
// Plane-serial Keccak theta: buffers five plane beats, then drains them XORed with D.
// Optional THETA_STREAM_PARITY_OUT_EN adds parity_out/parity_valid for trace.
module theta_stream
   import keccak_pkg::*;
#(
   parameter int W = 64
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [X_DIM*W-1:0] in_plane,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [X_DIM*W-1:0] out_plane,
   output logic [2:0]         out_y
`ifdef THETA_STREAM_PARITY_OUT_EN
   ,
   output logic [X_DIM*W-1:0] parity_out,
   output logic               parity_valid
`endif
);

   localparam int PW = X_DIM * W;
   localparam logic [0:0] ST_LOAD  = LOAD;
   localparam logic [0:0] ST_DRAIN = DRAIN;

   if (!lane_w_legal(W)) begin : g_bad_w
      $error("theta_stream: W must be one of 1,2,4,8,16,32,64");
   end

   logic [0:0]    state;
   logic [2:0]    in_cnt;
   logic [2:0]    out_cnt;
   logic [PW-1:0] c_q;
   logic [PW-1:0] d_q;
   logic [PW-1:0] c_next;
   logic [PW-1:0] d_next;
   logic [PW-1:0] pbuf [Y_DIM];
   logic          in_fire;
   logic          out_fire;
   logic          last_in;

   // Handshakes follow valid/ready: a beat transfers on a rising edge where both are high.
   assign in_ready  = (state == ST_LOAD);
   assign out_valid = (state == ST_DRAIN);
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;
   assign last_in   = in_fire && (in_cnt == 3'd4);
   assign c_next    = c_q ^ in_plane;

   theta_d #(.W(W)) u_theta_d (
      .c (c_next),
      .d (d_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_LOAD;
         in_cnt  <= 3'd0;
         out_cnt <= 3'd0;
         c_q     <= '0;
         d_q     <= '0;
      end else if (state == ST_LOAD) begin
         if (last_in) begin
            in_cnt <= 3'd0;
            c_q    <= '0;
            d_q    <= d_next;
            state  <= ST_DRAIN;
         end else if (in_fire) begin
            in_cnt <= in_cnt + 3'd1;
            c_q    <= c_next;
         end
      end else if (out_fire) begin
         if (out_cnt == 3'd4) begin
            out_cnt <= 3'd0;
            state   <= ST_LOAD;
         end else begin
            out_cnt <= out_cnt + 3'd1;
         end
      end
   end

   // Buffer contents are don't-care after reset, so no reset term here.
   always_ff @(posedge clk) begin
      if (in_fire) begin
         pbuf[in_cnt] <= in_plane;
      end
   end

   assign out_plane = pbuf[out_cnt] ^ d_q;
   assign out_y     = out_cnt;

`ifdef THETA_STREAM_PARITY_OUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         parity_out   <= '0;
         parity_valid <= 1'b0;
      end else begin
         parity_valid <= last_in;
         if (last_in) begin
            parity_out <= c_next;
         end
      end
   end
`endif

endmodule

// File: tb/tb_theta_stream.sv
// Directed/table-driven bench for theta_stream at W=64 and W=8.
module tb_theta_stream;
   import keccak_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [319:0] a_in_plane, a_out_plane;
   logic [2:0]   a_out_y;
   logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [39:0]  b_in_plane, b_out_plane;
   logic [2:0]   b_out_y;
`ifdef THETA_STREAM_PARITY_OUT_EN
   logic [319:0] a_parity_out;
   logic         a_parity_valid;
   logic [39:0]  b_parity_out;
   logic         b_parity_valid;
`endif

   theta_stream #(.W(64)) dut64 (
      .clk (clk), .rst_n (rst_n),
      .in_valid (a_in_valid), .in_ready (a_in_ready), .in_plane (a_in_plane),
      .out_valid (a_out_valid), .out_ready (a_out_ready), .out_plane (a_out_plane),
      .out_y (a_out_y)
`ifdef THETA_STREAM_PARITY_OUT_EN
      , .parity_out (a_parity_out), .parity_valid (a_parity_valid)
`endif
   );

   theta_stream #(.W(8)) dut8 (
      .clk (clk), .rst_n (rst_n),
      .in_valid (b_in_valid), .in_ready (b_in_ready), .in_plane (b_in_plane),
      .out_valid (b_out_valid), .out_ready (b_out_ready), .out_plane (b_out_plane),
      .out_y (b_out_y)
`ifdef THETA_STREAM_PARITY_OUT_EN
      , .parity_out (b_parity_out), .parity_valid (b_parity_valid)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;
   logic [319:0] exp_q[$];

   typedef struct {
      string              name;
      logic [4:0][319:0]  in_p;
      logic [4:0][319:0]  exp_p;
   } vec_t;
   vec_t vecs[4];

   task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Standard Keccak theta for W=8 lanes, written in lane-rotate form.
   function automatic logic [39:0] theta8(input logic [4:0][39:0] a, input int y);
      logic [7:0]  c[5];
      logic [7:0]  cr;
      logic [39:0] r;
      for (int x = 0; x < 5; x++) begin
         c[x] = 8'h00;
         for (int yy = 0; yy < 5; yy++) c[x] ^= a[yy][x*8 +: 8];
      end
      for (int x = 0; x < 5; x++) begin
         cr = c[(x + 1) % 5];
         r[x*8 +: 8] = a[y][x*8 +: 8] ^ c[(x + 4) % 5] ^ {cr[6:0], cr[7]};
      end
      return r;
   endfunction

   task automatic send_state(input bit w8, input logic [4:0][319:0] p, input string name);
      int t;
      logic [319:0] par;
      par = '0;
      for (int y = 0; y < 5; y++) begin
         if (w8) begin b_in_valid = 1'b1; b_in_plane = p[y][39:0]; end
         else    begin a_in_valid = 1'b1; a_in_plane = p[y]; end
         par ^= p[y];
         t = 0;
         while (!(w8 ? b_in_ready : a_in_ready) && t < 50) begin @(posedge clk); #1; t++; end
         check($sformatf("%s_in_ready_wait_y%0d", name, y), 320'(t < 50), 320'(1));
         check($sformatf("%s_no_early_valid_y%0d", name, y), 320'(w8 ? b_out_valid : a_out_valid), 320'(0));
         @(posedge clk); #1;
      end
      a_in_valid = 1'b0;
      b_in_valid = 1'b0;
      check($sformatf("%s_first_out_valid", name), 320'(w8 ? b_out_valid : a_out_valid), 320'(1));
`ifdef THETA_STREAM_PARITY_OUT_EN
      check($sformatf("%s_parity_valid", name), 320'(w8 ? b_parity_valid : a_parity_valid), 320'(1));
      check($sformatf("%s_parity_out", name), w8 ? {280'b0, b_parity_out} : a_parity_out, par);
`endif
   endtask

   task automatic recv_state(input bit w8, input string name);
      int t;
      logic [319:0] e;
      if (w8) b_out_ready = 1'b1; else a_out_ready = 1'b1;
      for (int y = 0; y < 5; y++) begin
         t = 0;
         while (!(w8 ? b_out_valid : a_out_valid) && t < 50) begin @(posedge clk); #1; t++; end
         check($sformatf("%s_out_valid_wait_y%0d", name, y), 320'(t < 50), 320'(1));
         if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL %s_exp_q_empty: got empty queue required entry", name);
         end else begin
            e = exp_q.pop_front();
            check($sformatf("%s_plane_y%0d", name, y), w8 ? {280'b0, b_out_plane} : a_out_plane, e);
         end
         check($sformatf("%s_out_y_%0d", name, y), 320'(w8 ? b_out_y : a_out_y), 320'(y));
         check($sformatf("%s_in_ready_drain_y%0d", name, y), 320'(w8 ? b_in_ready : a_in_ready), 320'(0));
`ifdef THETA_STREAM_PARITY_OUT_EN
         if (y > 0) check($sformatf("%s_parity_pulse_y%0d", name, y),
                          320'(w8 ? b_parity_valid : a_parity_valid), 320'(0));
`endif
         @(posedge clk); #1;
      end
      a_out_ready = 1'b0;
      b_out_ready = 1'b0;
      check($sformatf("%s_back_to_load", name), 320'(w8 ? b_in_ready : a_in_ready), 320'(1));
   endtask

   task automatic run_state(input bit w8, input logic [4:0][319:0] p, input logic [4:0][319:0] e,
                            input string name);
      for (int y = 0; y < 5; y++) exp_q.push_back(e[y]);
      send_state(w8, p, name);
      recv_state(w8, name);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [4:0][319:0] rp, re, stall_exp;
      logic [4:0][39:0]  rs;
      logic [319:0]      hold_plane;
      logic [2:0]        hold_y;

      a_in_valid = 0; a_out_ready = 0; a_in_plane = '0;
      b_in_valid = 0; b_out_ready = 0; b_in_plane = '0;

      // Directed vectors, bit index = x*W + z.
      for (int i = 0; i < 4; i++) begin
         vecs[i].in_p = '0;
         vecs[i].exp_p = '0;
      end
      vecs[0].name = "w64_zero";
      vecs[1].name = "w64_a000";
      vecs[1].in_p[0][0] = 1'b1;
      vecs[1].exp_p[0][0] = 1'b1;
      for (int y = 0; y < 5; y++) begin vecs[1].exp_p[y][64] = 1'b1; vecs[1].exp_p[y][257] = 1'b1; end
      vecs[2].name = "w64_zwrap";
      vecs[2].in_p[2][63] = 1'b1;
      vecs[2].exp_p[2][63] = 1'b1;
      for (int y = 0; y < 5; y++) begin vecs[2].exp_p[y][127] = 1'b1; vecs[2].exp_p[y][256] = 1'b1; end
      vecs[3].name = "w64_x3z5";
      vecs[3].in_p[4][197] = 1'b1;
      vecs[3].exp_p[4][197] = 1'b1;
      for (int y = 0; y < 5; y++) begin vecs[3].exp_p[y][261] = 1'b1; vecs[3].exp_p[y][134] = 1'b1; end

      #1;
      check("rst_in_ready", 320'(a_in_ready), 320'(1));
      check("rst_out_valid", 320'(a_out_valid), 320'(0));
      check("rst_out_y", 320'(a_out_y), 320'(0));
      check("rst8_in_ready", 320'(b_in_ready), 320'(1));
`ifdef THETA_STREAM_PARITY_OUT_EN
      check("rst_parity_valid", 320'(a_parity_valid), 320'(0));
`endif
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 4; i++) run_state(1'b0, vecs[i].in_p, vecs[i].exp_p, vecs[i].name);

      // W=8: A[0][0][7] -> lane1 bit7, lane4 bit0 on every plane.
      rp = '0; re = '0;
      rp[0][7] = 1'b1;
      re[0][7] = 1'b1;
      for (int y = 0; y < 5; y++) begin re[y][15] = 1'b1; re[y][32] = 1'b1; end
      run_state(1'b1, rp, re, "w8_a007");

      for (int n = 0; n < 20; n++) begin
         for (int y = 0; y < 5; y++) rs[y] = {8'($urandom), 32'($urandom)};
         for (int y = 0; y < 5; y++) begin
            rp[y] = {280'b0, rs[y]};
            re[y] = {280'b0, theta8(rs, y)};
         end
         run_state(1'b1, rp, re, $sformatf("w8_rand%0d", n));
      end

      // Backpressure on beat 2 with in_valid held high throughout DRAIN.
      stall_exp = vecs[1].exp_p;
      send_state(1'b0, vecs[1].in_p, "bp");
      a_in_valid = 1'b1;
      a_in_plane = {10{32'hdeadbeef}};
      a_out_ready = 1'b1;
      for (int y = 0; y < 5; y++) begin
         if (y == 2) begin
            a_out_ready = 1'b0;
            hold_plane = a_out_plane;
            hold_y = a_out_y;
            for (int k = 0; k < 3; k++) begin
               @(posedge clk); #1;
               check($sformatf("bp_hold_plane_%0d", k), a_out_plane, hold_plane);
               check($sformatf("bp_hold_y_%0d", k), 320'(a_out_y), 320'(hold_y));
               check($sformatf("bp_hold_valid_%0d", k), 320'(a_out_valid), 320'(1));
               check($sformatf("bp_hold_in_ready_%0d", k), 320'(a_in_ready), 320'(0));
            end
            a_out_ready = 1'b1;
         end
         check($sformatf("bp_plane_y%0d", y), a_out_plane, stall_exp[y]);
         check($sformatf("bp_out_y_%0d", y), 320'(a_out_y), 320'(y));
         check($sformatf("bp_in_ready_y%0d", y), 320'(a_in_ready), 320'(0));
         @(posedge clk); #1;
      end
      a_in_valid = 1'b0;
      a_out_ready = 1'b0;
      check("bp_back_to_load", 320'(a_in_ready), 320'(1));

      // Reset after three accepted beats of junk; the next state must be clean.
      a_in_valid = 1'b1;
      for (int y = 0; y < 3; y++) begin
         a_in_plane = {10{$urandom}};
         @(posedge clk); #1;
      end
      a_in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("midrst_in_ready", 320'(a_in_ready), 320'(1));
      check("midrst_out_valid", 320'(a_out_valid), 320'(0));
      check("midrst_out_y", 320'(a_out_y), 320'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_state(1'b0, vecs[2].in_p, vecs[2].exp_p, "post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
